// File: rtl/mem_bridge.sv
// External-bus slave: demultiplexes the core's address/data bus on ALE and turns
// nME/nOE strobes into a request/acknowledge access with wait states and timeout.
module mem_bridge #(
    parameter int WAIT_CYCLES = 1,
    parameter int TIMEOUT     = 32
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [15:0] AdBus,
    input  logic        ALE,
    input  logic        nME,
    input  logic        nOE,
    output logic [15:0] DataIn,
    output logic        nWait,
    output logic        MemReq,
    output logic        MemWr,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWData,
    input  logic [15:0] MemRData,
    input  logic        MemAck,
    output logic        BusErr
);

    typedef enum logic [1:0] {IDLE, WAIT, REQ, DONE} bridgeState;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

    bridgeState  state, stateNext;
    logic [3:0]  waitCnt, waitCntNext;
    logic [7:0]  toCnt, toCntNext;
    logic        nmeRose, nmeRoseNext;
    logic [15:0] dataInNext, memAddrNext, memWDataNext;
    logic        nWaitNext, memReqNext, memWrNext, busErrNext;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            waitCnt  <= '0;
            toCnt    <= '0;
            nmeRose  <= 1'b0;
            DataIn   <= '0;
            nWait    <= 1'b1;
            MemReq   <= 1'b0;
            MemWr    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            BusErr   <= 1'b0;
        end else begin
            state    <= stateNext;
            waitCnt  <= waitCntNext;
            toCnt    <= toCntNext;
            nmeRose  <= nmeRoseNext;
            DataIn   <= dataInNext;
            nWait    <= nWaitNext;
            MemReq   <= memReqNext;
            MemWr    <= memWrNext;
            MemAddr  <= memAddrNext;
            MemWData <= memWDataNext;
            BusErr   <= busErrNext;
        end
    end

    always_comb begin
        stateNext    = state;
        waitCntNext  = waitCnt;
        toCntNext    = toCnt;
        nmeRoseNext  = nmeRose;
        dataInNext   = DataIn;
        nWaitNext    = nWait;
        memReqNext   = MemReq;
        memWrNext    = MemWr;
        memAddrNext  = MemAddr;
        memWDataNext = MemWData;
        busErrNext   = 1'b0;
        unique case (state)
            IDLE: begin
                // Address latched on the same edge as nME is used for that access.
                if (ALE) memAddrNext = AdBus;
                if (!nME) begin
                    memWrNext   = nOE;
                    nWaitNext   = 1'b0;
                    waitCntNext = '0;
                    toCntNext   = '0;
                    nmeRoseNext = 1'b0;
                    if (nOE) memWDataNext = AdBus;
                    if (WAIT_CYCLES > 0) begin
                        stateNext = WAIT;
                    end else begin
                        stateNext  = REQ;
                        memReqNext = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (nME) begin
                    stateNext   = IDLE;
                    nWaitNext   = 1'b1;
                    waitCntNext = '0;
                end else if (waitCnt == WAIT_LAST) begin
                    stateNext   = REQ;
                    memReqNext  = 1'b1;
                    waitCntNext = '0;
                end else begin
                    waitCntNext = waitCnt + 4'd1;
                end
            end
            REQ: begin
                if (nME) nmeRoseNext = 1'b1;
                if (MemAck || toCnt == TO_LAST) begin
                    memReqNext  = 1'b0;
                    nWaitNext   = 1'b1;
                    toCntNext   = '0;
                    nmeRoseNext = 1'b0;
                    // Core already released the strobe: skip DONE and go straight back.
                    stateNext   = (nmeRose || nME) ? IDLE : DONE;
                    if (MemAck) begin
                        if (!MemWr) dataInNext = MemRData;
                    end else begin
                        busErrNext = 1'b1;
                        if (!MemWr) dataInNext = 16'hFFFF;
                    end
                end else begin
                    toCntNext = toCnt + 8'd1;
                end
            end
            DONE: begin
                if (nME) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule
